ahb_cfg_slave: RTL and testbench

//  AHB-Lite slave that sits directly behind the AHB bus interface. It decodes

---
 rtl/ahb_cfg_slave.sv | 164 ++++++++++++++++
 tb/tb_ahb_cfg_slave.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_cfg_slave.sv
// AHB-Lite configuration slave for the edge-detector core: register file,
// start pulse, status/done tracking and a registered done interrupt.
module ahb_cfg_slave #(
    parameter int BUSWIDTH = 32,
    parameter int DIM_W    = 16
) (
    input  logic                ahb_hclk,
    input  logic                ahb_hreset,
    input  logic                ahb_hsel,
    input  logic [1:0]          ahb_htrans,
    input  logic                ahb_hwrite,
    input  logic [BUSWIDTH-1:0] ahb_haddr,
    input  logic [BUSWIDTH-1:0] ahb_hwdata,
    output logic [BUSWIDTH-1:0] ahb_hrdata,
    output logic                ahb_hready,
    output logic                ahb_hresp,
    input  logic                core_busy,
    input  logic                core_done,
    output logic                cfg_start,
    output logic [BUSWIDTH-1:0] cfg_src_addr,
    output logic [BUSWIDTH-1:0] cfg_dst_addr,
    output logic [DIM_W-1:0]    cfg_width,
    output logic [DIM_W-1:0]    cfg_height,
    output logic                irq
);

    localparam logic [2:0] OFF_CTRL = 3'd0;
    localparam logic [2:0] OFF_STAT = 3'd1;
    localparam logic [2:0] OFF_SRC  = 3'd2;
    localparam logic [2:0] OFF_DST  = 3'd3;
    localparam logic [2:0] OFF_SIZE = 3'd4;

    // A rejected write's data phase is itself the first error cycle
    // (hready=0, hresp=1); ERR2 is the closing cycle of the response.
    typedef enum logic [1:0] {IDLE, WDATA, RDATA, ERR2} state_t;

    state_t              state, state_nxt;
    logic [2:0]          off_q;
    logic                accept, illegal, wr_commit;
    logic [BUSWIDTH-1:0] src_q, dst_q, src_d, dst_d, rd_val;
    logic [DIM_W-1:0]    width_q, height_q, width_d, height_d;
    logic                irq_en_q, irq_en_d, done_q, done_d;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^{ahb_haddr[BUSWIDTH-1:5], ahb_haddr[1:0]};

    always_comb begin
        illegal = 1'b0;
        if (state == WDATA) begin
            if (off_q == OFF_CTRL && ahb_hwdata[0] &&
                (core_busy || width_q == '0 || height_q == '0))
                illegal = 1'b1;
            if (off_q == OFF_SIZE && core_busy)
                illegal = 1'b1;
        end
    end

    assign wr_commit = (state == WDATA) && !illegal;
    assign accept    = ahb_hsel && ahb_htrans[1] && ahb_hready && (state != ERR2);

    always_ff @(posedge ahb_hclk or posedge ahb_hreset) begin
        if (ahb_hreset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = IDLE;
        if (state == WDATA && illegal)
            state_nxt = ERR2;
        else if (accept)
            state_nxt = ahb_hwrite ? WDATA : RDATA;
    end

    always_comb begin
        ahb_hready = 1'b1;
        ahb_hresp  = 1'b0;
        case (state)
            WDATA: begin
                if (illegal) begin
                    ahb_hready = 1'b0;
                    ahb_hresp  = 1'b1;
                end
            end
            ERR2:    ahb_hresp = 1'b1;
            default: ;
        endcase
    end

    // Next-cycle register view; reading from it gives read-after-write forwarding.
    always_comb begin
        src_d    = src_q;
        dst_d    = dst_q;
        width_d  = width_q;
        height_d = height_q;
        irq_en_d = irq_en_q;
        if (wr_commit) begin
            case (off_q)
                OFF_CTRL: irq_en_d = ahb_hwdata[1];
                OFF_SRC:  src_d    = ahb_hwdata;
                OFF_DST:  dst_d    = ahb_hwdata;
                OFF_SIZE: begin
                    width_d  = ahb_hwdata[DIM_W-1:0];
                    height_d = ahb_hwdata[16 +: DIM_W];
                end
                default: ;
            endcase
        end
        done_d = core_done ||
                 (done_q && !(wr_commit && off_q == OFF_STAT && ahb_hwdata[1]));
    end

    always_comb begin
        rd_val = '0;
        case (ahb_haddr[4:2])
            OFF_CTRL: rd_val[1] = irq_en_d;
            OFF_STAT: begin
                rd_val[0] = core_busy;
                rd_val[1] = done_d;
            end
            OFF_SRC:  rd_val = src_d;
            OFF_DST:  rd_val = dst_d;
            OFF_SIZE: begin
                rd_val[DIM_W-1:0]  = width_d;
                rd_val[16 +: DIM_W] = height_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge ahb_hclk or posedge ahb_hreset) begin
        if (ahb_hreset) begin
            off_q      <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            width_q    <= '0;
            height_q   <= '0;
            irq_en_q   <= 1'b0;
            done_q     <= 1'b0;
            cfg_start  <= 1'b0;
            irq        <= 1'b0;
            ahb_hrdata <= '0;
        end else begin
            if (accept)
                off_q <= ahb_haddr[4:2];
            src_q      <= src_d;
            dst_q      <= dst_d;
            width_q    <= width_d;
            height_q   <= height_d;
            irq_en_q   <= irq_en_d;
            done_q     <= done_d;
            cfg_start  <= wr_commit && off_q == OFF_CTRL && ahb_hwdata[0];
            irq        <= done_q && irq_en_q;
            ahb_hrdata <= (accept && !ahb_hwrite) ? rd_val : '0;
        end
    end

    assign cfg_src_addr = src_q;
    assign cfg_dst_addr = dst_q;
    assign cfg_width    = width_q;
    assign cfg_height   = height_q;

endmodule

// File: tb/tb_ahb_cfg_slave.sv
// Bench for ahb_cfg_slave: directed scenarios followed by random register
// traffic, checked against a register-level model of the slave.
module tb_ahb_cfg_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        hsel = 1'b0, hwrite = 1'b0;
    logic [1:0]  htrans = 2'd0;
    logic [31:0] haddr = '0, hwdata = '0;
    logic [31:0] hrdata;
    logic        hready, hresp;
    logic        core_busy = 1'b0, core_done = 1'b0;
    logic        cfg_start, irq;
    logic [31:0] cfg_src_addr, cfg_dst_addr;
    logic [15:0] cfg_width, cfg_height;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_src, m_dst;
    logic [15:0] m_w, m_h;
    logic        m_irq_en, m_done;

    always #5 clk = ~clk;

    ahb_cfg_slave #(.BUSWIDTH(32), .DIM_W(16)) dut (
        .ahb_hclk(clk), .ahb_hreset(rst), .ahb_hsel(hsel), .ahb_htrans(htrans),
        .ahb_hwrite(hwrite), .ahb_haddr(haddr), .ahb_hwdata(hwdata),
        .ahb_hrdata(hrdata), .ahb_hready(hready), .ahb_hresp(hresp),
        .core_busy(core_busy), .core_done(core_done), .cfg_start(cfg_start),
        .cfg_src_addr(cfg_src_addr), .cfg_dst_addr(cfg_dst_addr),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .irq(irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        hsel = 1'b0; htrans = 2'd0; hwrite = 1'b0;
    endtask

    task automatic model_reset();
        m_src = '0; m_dst = '0; m_w = '0; m_h = '0; m_irq_en = 1'b0; m_done = 1'b0;
    endtask

    function automatic logic [31:0] model_read(input logic [2:0] off);
        case (off)
            3'd0:    return {30'd0, m_irq_en, 1'b0};
            3'd1:    return {30'd0, m_done, core_busy};
            3'd2:    return m_src;
            3'd3:    return m_dst;
            3'd4:    return {m_h, m_w};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic is_ill(input logic [2:0] off, input logic [31:0] data);
        return (off == 3'd0 && data[0] && (core_busy || m_w == 16'd0 || m_h == 16'd0)) ||
               (off == 3'd4 && core_busy);
    endfunction

    function automatic void model_write(input logic [2:0] off, input logic [31:0] data,
                                        input logic done_in);
        logic clr;
        clr    = (off == 3'd1) && data[1];
        m_done = done_in || (m_done && !clr);
        case (off)
            3'd0: m_irq_en = data[1];
            3'd2: m_src = data;
            3'd3: m_dst = data;
            3'd4: {m_h, m_w} = data;
            default: ;
        endcase
    endfunction

    task automatic check_cfg();
        chk("src_addr", cfg_src_addr, m_src);
        chk("dst_addr", cfg_dst_addr, m_dst);
        chk("width", {16'd0, cfg_width}, {16'd0, m_w});
        chk("height", {16'd0, cfg_height}, {16'd0, m_h});
        chk("irq", {31'd0, irq}, {31'd0, m_done & m_irq_en});
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic done_in);
        logic [2:0] off;
        logic       ill;
        off  = addr[4:2];
        hsel = 1'b1; htrans = 2'd2; hwrite = 1'b1; haddr = addr;
        tick();
        bus_idle();
        hwdata    = data;
        core_done = done_in;
        ill       = is_ill(off, data);
        @(negedge clk);
        chk("wdata_hready", {31'd0, hready}, {31'd0, !ill});
        chk("wdata_hresp", {31'd0, hresp}, {31'd0, ill});
        tick();
        core_done = 1'b0;
        if (ill)
            m_done = done_in || m_done;
        else
            model_write(off, data, done_in);
        chk("cfg_start", {31'd0, cfg_start}, {31'd0, !ill && off == 3'd0 && data[0]});
        if (ill) begin
            @(negedge clk);
            chk("err2_hready", {31'd0, hready}, 32'd1);
            chk("err2_hresp", {31'd0, hresp}, 32'd1);
        end
        tick();
        chk("cfg_start_end", {31'd0, cfg_start}, 32'd0);
        check_cfg();
    endtask

    task automatic do_read(input logic [31:0] addr);
        logic [31:0] exp;
        hsel = 1'b1; htrans = 2'd2; hwrite = 1'b0; haddr = addr;
        exp = model_read(addr[4:2]);
        tick();
        bus_idle();
        @(negedge clk);
        chk("rdata", hrdata, exp);
        chk("rdata_hready", {31'd0, hready}, 32'd1);
        chk("rdata_hresp", {31'd0, hresp}, 32'd0);
        tick();
    endtask

    // Legal write immediately followed by a read of the same register.
    task automatic do_wr_rd(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] exp;
        hsel = 1'b1; htrans = 2'd2; hwrite = 1'b1; haddr = addr;
        tick();
        hwdata = data;
        hwrite = 1'b0;
        @(negedge clk);
        chk("b2b_hready", {31'd0, hready}, 32'd1);
        model_write(addr[4:2], data, 1'b0);
        exp = model_read(addr[4:2]);
        tick();
        bus_idle();
        chk("b2b_start", {31'd0, cfg_start}, {31'd0, addr[4:2] == 3'd0 && data[0]});
        @(negedge clk);
        chk("b2b_rdata", hrdata, exp);
        chk("b2b_rd_hready", {31'd0, hready}, 32'd1);
        tick();
        check_cfg();
    endtask

    task automatic pulse_done();
        logic old_irq;
        old_irq   = m_done & m_irq_en;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        m_done    = 1'b1;
        chk("irq_lag", {31'd0, irq}, {31'd0, old_irq});
        tick();
        chk("irq_after_done", {31'd0, irq}, {31'd0, m_irq_en});
    endtask

    initial begin
        logic [2:0]  off;
        logic [31:0] addr, data;
        int unsigned kind;

        model_reset();
        #1 rst = 1'b1;
        tick();
        tick();
        @(negedge clk);
        chk("rst_hready", {31'd0, hready}, 32'd1);
        chk("rst_hresp", {31'd0, hresp}, 32'd0);
        chk("rst_hrdata", hrdata, 32'd0);
        chk("rst_start", {31'd0, cfg_start}, 32'd0);
        check_cfg();
        rst = 1'b0;
        tick();

        do_read(32'h0000_0008);
        do_wr_rd(32'h0000_0008, 32'h1000_0000);

        do_write(32'h0000_0010, 32'h01E0_0280, 1'b0);
        do_write(32'h0000_0000, 32'h0000_0003, 1'b0);
        chk("width_640", {16'd0, cfg_width}, 32'd640);
        chk("height_480", {16'd0, cfg_height}, 32'd480);

        core_busy = 1'b1;
        do_write(32'h0000_0000, 32'h0000_0001, 1'b0);
        do_write(32'h0000_0010, 32'h0002_0002, 1'b0);
        do_read(32'h0000_0004);
        core_busy = 1'b0;

        pulse_done();
        do_write(32'h0000_0004, 32'h0000_0002, 1'b0);
        pulse_done();
        do_write(32'h0000_0004, 32'h0000_0002, 1'b1);
        do_read(32'h0000_0004);
        do_write(32'h0000_0014, 32'hFFFF_FFFF, 1'b0);
        do_read(32'h0000_001C);

        // reset asserted during the data phase of a SRC_ADDR write
        hsel = 1'b1; htrans = 2'd2; hwrite = 1'b1; haddr = 32'h0000_0008;
        tick();
        bus_idle();
        hwdata = 32'hDEAD_BEEF;
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("midrst_hready", {31'd0, hready}, 32'd1);
        chk("midrst_hresp", {31'd0, hresp}, 32'd0);
        tick();
        chk("midrst_start", {31'd0, cfg_start}, 32'd0);
        check_cfg();
        do_read(32'h0000_0008);

        for (int i = 0; i < 80; i++) begin
            core_busy = ($urandom_range(0, 3) == 0);
            off  = 3'($urandom_range(0, 7));
            addr = ($urandom & 32'hFFFF_FFE0) | {27'd0, off, 2'b00};
            data = $urandom;
            if (off == 3'd4 && $urandom_range(0, 3) == 0)
                data[31:16] = 16'd0;
            kind = $urandom_range(0, 5);
            case (kind)
                0, 1: do_write(addr, data, 1'b0);
                2:    do_read(addr);
                3, 4: begin
                    if (is_ill(off, data))
                        do_write(addr, data, 1'b0);
                    else
                        do_wr_rd(addr, data);
                end
                default: pulse_done();
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
